// File: rtl/burst_memory.sv
// burst_memory: word-addressed memory responder with read wait states; multi-beat bursts
// when BURST_EN is defined, otherwise every request is a single beat. Array is never reset.
module burst_memory #(
    parameter logic [31:0] MEM_START   = 32'h8002_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [1:0]  access_size,
    input  logic        rd_wr,
    input  logic        enable,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        err
);
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT     = 33'(MEM_START) + 33'(4 * DEPTH_WORDS) - 33'd1;
    localparam logic [2:0]  WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RD_BURST, WR_BURST} state_t;

    state_t        state_q;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] ptr_q;
    logic [2:0]    wcnt_q;
    logic          rd_q;
    logic [31:0]   data_out_q;
    logic          busy_q;
    logic          err_q;

    logic [4:0]    req_beats;
    logic [32:0]   req_end;
    logic [31:0]   req_off;
    logic [AW-1:0] req_idx;
    logic          req_ok;
    logic          req_multi;
    logic          more_beats;

`ifdef BURST_EN
    logic [3:0] beat_q;
    logic [3:0] last_q;

    always_comb begin
        req_beats = 5'd1;
        case (access_size)
            2'b00:   req_beats = 5'd1;
            2'b01:   req_beats = 5'd4;
            2'b10:   req_beats = 5'd8;
            default: req_beats = 5'd16;
        endcase
    end

    assign req_multi  = (req_beats != 5'd1);
    assign more_beats = (last_q != 4'd0);
`else
    logic unused_size;
    assign unused_size = ^access_size;
    assign req_beats   = 5'd1;
    assign req_multi   = 1'b0;
    assign more_beats  = 1'b0;
`endif

    // Range check in 33 bits so a burst running past 2^32 cannot wrap into range.
    assign req_end = {1'b0, addr} + {26'd0, req_beats, 2'b00} - 33'd1;
    assign req_off = addr - MEM_START;
    assign req_idx = req_off[AW+1:2];
    assign req_ok  = (addr[1:0] == 2'b00) && (addr >= MEM_START) && (req_end <= LIMIT);

    logic unused_off;
    assign unused_off = ^{req_off[31:AW+2], req_off[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
            wcnt_q     <= '0;
            rd_q       <= 1'b0;
`ifdef BURST_EN
            beat_q     <= '0;
            last_q     <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (enable) begin
                        if (!req_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            rd_q   <= rd_wr;
                            wcnt_q <= WAIT_INIT;
                            ptr_q  <= req_idx + AW'(1);
`ifdef BURST_EN
                            last_q <= req_beats[3:0] - 4'd1;
                            beat_q <= 4'd1;
`endif
                            // Write beat 0 always lands at acceptance, even with wait states.
                            if (!rd_wr) mem_q[req_idx] <= data_in;
                            if (WAIT_STATES != 0) begin
                                if (rd_wr) ptr_q <= req_idx;
                                state_q <= WAIT;
                                busy_q  <= 1'b1;
                            end else begin
                                if (rd_wr) data_out_q <= mem_q[req_idx];
                                if (req_multi) begin
                                    state_q <= rd_wr ? RD_BURST : WR_BURST;
                                    busy_q  <= 1'b1;
                                end
                            end
                        end
                    end
                end

                WAIT: begin
                    if (wcnt_q != 3'd0) begin
                        wcnt_q <= wcnt_q - 3'd1;
                    end else begin
                        if (rd_q) begin
                            data_out_q <= mem_q[ptr_q];
                            ptr_q      <= ptr_q + AW'(1);
                        end
                        if (more_beats) begin
                            state_q <= rd_q ? RD_BURST : WR_BURST;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

`ifdef BURST_EN
                RD_BURST, WR_BURST: begin
                    if (state_q == RD_BURST) data_out_q <= mem_q[ptr_q];
                    else                     mem_q[ptr_q] <= data_in;
                    ptr_q <= ptr_q + AW'(1);
                    // busy drops one cycle early so the next request can land on the edge after the last beat.
                    if (beat_q == last_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        beat_q <= beat_q + 4'd1;
                    end
                end
`endif

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign err      = err_q;
endmodule

// File: tb/tb_burst_memory.sv
// Bench for burst_memory: two instances (no wait states, two wait states) driven with directed and
// random requests; every cycle's busy/err/data_out is checked against a beat-timing model.
`timescale 1ns/1ps
module tb_burst_memory;
    localparam logic [31:0] MS    = 32'h8002_0000;
    localparam int          DEPTH = 1024;
    localparam int          WS1   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_s    [2];
    logic [31:0] addr_s     [2];
    logic [31:0] data_in_s  [2];
    logic [1:0]  size_s     [2];
    logic        rd_wr_s    [2];
    logic        enable_s   [2];
    logic [31:0] data_out_s [2];
    logic        busy_s     [2];
    logic        err_s      [2];

    burst_memory #(.MEM_START(MS), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_mem0 (
        .clk(clk), .reset(reset_s[0]), .addr(addr_s[0]), .data_in(data_in_s[0]),
        .access_size(size_s[0]), .rd_wr(rd_wr_s[0]), .enable(enable_s[0]),
        .data_out(data_out_s[0]), .busy(busy_s[0]), .err(err_s[0]));

    burst_memory #(.MEM_START(MS), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_mem1 (
        .clk(clk), .reset(reset_s[1]), .addr(addr_s[1]), .data_in(data_in_s[1]),
        .access_size(size_s[1]), .rd_wr(rd_wr_s[1]), .enable(enable_s[1]),
        .data_out(data_out_s[1]), .busy(busy_s[1]), .err(err_s[1]));

    logic [31:0] model_mem  [2][DEPTH];
    logic [31:0] model_dout [2];
    logic [31:0] wbuf [16];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic int wait_of(input int s);
        return (s == 0) ? 0 : WS1;
    endfunction

    function automatic int nbeats(input logic [1:0] sz);
`ifdef BURST_EN
        case (sz)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
`else
        return (sz == 2'b00) ? 1 : 1;
`endif
    endfunction

    function automatic bit rejects(input logic [31:0] a, input int n);
        longint unsigned hi, last_b;
        hi     = 64'(MS) + 64'(4 * DEPTH) - 64'd1;
        last_b = 64'(a) + 64'(4 * n) - 64'd1;
        return (a[1:0] != 2'b00) || (a < MS) || (last_b > hi);
    endfunction

    // Issue one request at the next edge and check every cycle until the edge a follow-up could be accepted.
    task automatic run_req(input int s, input logic [31:0] a, input logic [1:0] sz, input logic rd, input string tag);
        int n, w, idx, cycles, k;
        bit rej;
        logic eb, ee;
        n      = nbeats(sz);
        w      = wait_of(s);
        rej    = rejects(a, n);
        idx    = int'((a - MS) >> 2);
        cycles = rej ? 1 : w + n;
        addr_s[s] = a; size_s[s] = sz; rd_wr_s[s] = rd; enable_s[s] = 1'b1; data_in_s[s] = wbuf[0];
        if (!rd && !rej) model_mem[s][idx] = wbuf[0];
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            if (j == cycles - 1) begin
                enable_s[s] = 1'b0;
            end else begin
                enable_s[s] = 1'($urandom);
                addr_s[s]   = $urandom;
                size_s[s]   = 2'($urandom);
                rd_wr_s[s]  = 1'($urandom);
            end
            data_in_s[s] = $urandom;
            k = j + 1 - w;
            if (!rd && !rej && k >= 1 && k <= n - 1) begin
                data_in_s[s] = wbuf[k];
                model_mem[s][idx + k] = wbuf[k];
            end
            if (rd && !rej && j >= w) model_dout[s] = model_mem[s][idx + j - w];
            eb = !rej && (j <= w + n - 2);
            ee = rej && (j == 0);
            n_cmp++;
            if (busy_s[s] !== eb) begin
                n_bad++;
                $display("FAIL %s busy inst%0d cyc%0d: got %0b want %0b", tag, s, j, busy_s[s], eb);
            end
            n_cmp++;
            if (err_s[s] !== ee) begin
                n_bad++;
                $display("FAIL %s err inst%0d cyc%0d: got %0b want %0b", tag, s, j, err_s[s], ee);
            end
            n_cmp++;
            if (data_out_s[s] !== model_dout[s]) begin
                n_bad++;
                $display("FAIL %s data_out inst%0d cyc%0d: got %h want %h", tag, s, j, data_out_s[s], model_dout[s]);
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) reset_s[s] = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            model_dout[s] = 32'h0;
            n_cmp++;
            if (data_out_s[s] !== 32'h0) begin
                n_bad++; $display("FAIL reset data_out inst%0d: got %h want 0", s, data_out_s[s]);
            end
            n_cmp++;
            if (busy_s[s] !== 1'b0 || err_s[s] !== 1'b0) begin
                n_bad++; $display("FAIL reset busy/err inst%0d: got %0b/%0b want 0/0", s, busy_s[s], err_s[s]);
            end
            reset_s[s] = 1'b0;
        end
    endtask

    task automatic prefill();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 96; i++) begin
                wbuf[0] = $urandom;
                run_req(s, MS + 32'(4 * ((i < 48) ? i : DEPTH - 96 + i)), 2'b00, 1'b0, "prefill");
            end
        end
    endtask

    task automatic test_single();
        wbuf[0] = 32'hCAFE_F00D;
        run_req(0, MS, 2'b00, 1'b0, "single_wr");
        run_req(0, MS, 2'b00, 1'b1, "single_rd");
    endtask

    task automatic test_burst4();
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
            run_req(s, MS + 32'h10, 2'b01, 1'b0, "b4_wr");
            run_req(s, MS + 32'h10, 2'b01, 1'b1, "b4_rd");
            run_req(s, MS, 2'b00, 1'b1, "b4_next");
            run_req(s, MS + 32'h10, 2'b11, 1'b1, "size16_rd");
        end
    endtask

    task automatic test_reject();
        for (int s = 0; s < 2; s++) begin
            run_req(s, MS + 32'h2, 2'b00, 1'b1, "rej_misalign");
            run_req(s, MS + 32'(4 * (DEPTH - 8)), 2'b11, 1'b1, "rej_overrun");
            run_req(s, MS - 32'h4, 2'b00, 1'b1, "rej_below");
            wbuf[0] = 32'h5A5A_0001;
            run_req(s, MS - 32'h8, 2'b00, 1'b0, "rej_wr_below");
            run_req(s, MS + 32'(4 * (DEPTH - 1)), 2'b00, 1'b1, "last_word");
            run_req(s, MS + 32'(4 * (DEPTH - 4)), 2'b01, 1'b1, "end_fit");
            run_req(s, MS + 32'(4 * (DEPTH - 3)), 2'b01, 1'b1, "end_over");
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] base;
        int n;
        base = MS + 32'h40;
        n    = nbeats(2'b11);
        for (int k = 0; k < 16; k++) wbuf[k] = 32'h100 + 32'(k);
        if (n == 16) begin
            run_req(0, base, 2'b11, 1'b0, "mb_fill");
        end else begin
            for (int k = 0; k < 16; k++) begin
                wbuf[0] = 32'h100 + 32'(k);
                run_req(0, base + 32'(4 * k), 2'b00, 1'b0, "mb_fill");
            end
        end
        addr_s[0] = base; size_s[0] = 2'b11; rd_wr_s[0] = 1'b1; enable_s[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            enable_s[0] = 1'b0;
            model_dout[0] = model_mem[0][16 + ((j < n) ? j : n - 1)];
            n_cmp++;
            if (data_out_s[0] !== model_dout[0]) begin
                n_bad++; $display("FAIL mb_beat%0d data_out: got %h want %h", j, data_out_s[0], model_dout[0]);
            end
        end
        reset_s[0] = 1'b1;
        @(negedge clk);
        reset_s[0] = 1'b0;
        model_dout[0] = 32'h0;
        n_cmp++;
        if (busy_s[0] !== 1'b0 || err_s[0] !== 1'b0) begin
            n_bad++; $display("FAIL mb_reset busy/err: got %0b/%0b want 0/0", busy_s[0], err_s[0]);
        end
        n_cmp++;
        if (data_out_s[0] !== 32'h0) begin
            n_bad++; $display("FAIL mb_reset data_out: got %h want 0", data_out_s[0]);
        end
        run_req(0, base + 32'h14, 2'b00, 1'b1, "mb_word5");
        n_cmp++;
        if (data_out_s[0] !== 32'h105) begin
            n_bad++; $display("FAIL mb_word5 value: got %h want 105", data_out_s[0]);
        end
    endtask

    task automatic test_wait_states();
        wbuf[0] = 32'h1234_5678;
        run_req(1, MS + 32'(4 * 40), 2'b00, 1'b0, "ws_wr");
        run_req(1, MS + 32'(4 * 40), 2'b00, 1'b1, "ws_rd");
        for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
        run_req(1, MS + 32'(4 * 20), 2'b10, 1'b0, "ws_b8_wr");
        run_req(1, MS + 32'(4 * 20), 2'b10, 1'b1, "ws_b8_rd");
    endtask

    task automatic test_random();
        for (int r = 0; r < 80; r++) begin
            int s, word;
            logic [31:0] a;
            logic [1:0] sz;
            logic rd;
            s  = $urandom_range(0, 1);
            sz = 2'($urandom);
            rd = 1'($urandom);
            if ($urandom_range(0, 1) == 0) word = $urandom_range(0, 31);
            else                           word = $urandom_range(DEPTH - 48, DEPTH - 1);
            a = MS + 32'(4 * word);
            case ($urandom_range(0, 9))
                0:       a = a + 32'($urandom_range(1, 3));
                1:       a = MS - 32'(4 * $urandom_range(1, 8));
                default: ;
            endcase
            for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
            run_req(s, a, sz, rd, "random");
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            reset_s[s] = 1'b1; addr_s[s] = '0; data_in_s[s] = '0; size_s[s] = '0;
            rd_wr_s[s] = 1'b0; enable_s[s] = 1'b0; model_dout[s] = '0;
        end
        @(negedge clk);
        test_reset();
        prefill();
        test_single();
        test_burst4();
        test_reject();
        test_reset_mid_burst();
        test_wait_states();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/burst_memory.md
# burst_memory

Word-addressed memory responder that serves the core's instruction-fetch and load/store requests. It implements the responder side of the `addr` / `data_in` / `access_size` / `rd_wr` / `enable` / `data_out` / `busy` memory interface, including multi-beat bursts and configurable read wait states. It is instantiated once for instruction memory and once for data memory, in place of the behavioural store.

## Interface
Parameters:
- `MEM_START`, default 32'h8002_0000: byte address of word 0.
- `DEPTH_WORDS`, default 1024: number of 32-bit words (power of two).
- `WAIT_STATES`, default 0: idle cycles between request acceptance and the first beat (0–7).

Ports:
- `clk`, input, 1: clock; all logic is on the rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `addr`, input, 32: byte address of the first beat.
- `data_in`, input, 32: write data, one word per beat.
- `access_size`, input, 2: burst length; 00 = 1, 01 = 4, 10 = 8, 11 = 16 words.
- `rd_wr`, input, 1: 1 = read, 0 = write.
- `enable`, input, 1: request valid.
- `data_out`, output, 32: registered read data.
- `busy`, output, 1: responder cannot accept a new request.
- `err`, output, 1: one-cycle pulse flagging a rejected request.

## Operation
- **States:** IDLE, WAIT, RD_BURST, WR_BURST.
- **Acceptance:** a request is accepted at edge T0 when the state is IDLE, `enable`=1 and `reset`=0.
  - `addr`, `access_size` and `rd_wr` are latched at T0.
  - All later changes to these inputs, and to `enable`, are ignored until the burst ends.
- **Rejection:** a request is rejected when `addr[1:0]`≠0, `addr`<`MEM_START`, or `addr`+4·N−1 > `MEM_START`+4·`DEPTH_WORDS`−1.
  - On rejection: `err`=1 for the cycle after T0, no access is made, `data_out` is unchanged, and the state stays IDLE.
- **Burst addressing:** linear, +4 per beat, no wrap. The range check above guarantees the burst stays inside the array.
- **Reads:**
  - If `WAIT_STATES`=0, go to RD_BURST. Otherwise go to WAIT for `WAIT_STATES` cycles, then RD_BURST.
  - Beat k is on `data_out` for exactly one cycle, in consecutive cycles.
  - After the last beat, `data_out` holds that beat's value.
- **Writes:**
  - Beat 0 is `data_in` sampled at T0 and is written immediately.
  - Go to WAIT (if `WAIT_STATES`>0), then WR_BURST. Beat k (k≥1) is sampled from `data_in` at the edge ending the k-th cycle after the wait.
  - `data_out` is unchanged by writes.
- **Single-beat requests:** go straight back to IDLE after the access (after WAIT when `WAIT_STATES`>0).
- **Memory array:** not cleared by reset; its contents survive reset.
- **Reset mid-burst:** state goes to IDLE. In the cycle after the reset edge, `busy`=0, `err`=0 and `data_out`=0. Remaining beats are dropped. Beats already written stay written.

## Timing
- **Reset values:** `data_out`=32'h0, `busy`=0, `err`=0.
- **Beat timing, `WAIT_STATES`=W:**
  - Read beat k is valid in the cycle after edge T(W+k).
  - Write beat k is sampled at edge T(W+k).
- **busy:**
  - `busy`=1 from the cycle after T0 through the cycle after T(W+N−2).
  - `busy` is 0 during the last beat's cycle.
  - For N=1 and W=0, `busy` is never asserted.
- **Back-to-back requests:** a new request can be accepted at edge T(W+N), so bursts run back-to-back with no gap.
- **Read latency:** 1 cycle from acceptance to beat 0 for W=0, or W+1 cycles in general.
- **err:** asserted for the cycle after T0 only, and never together with `busy`.

## Configuration
- **`BURST_EN` defined:** `access_size` selects N as listed above.
- **`BURST_EN` undefined:**
  - `access_size` is ignored and every request is single-beat (N=1).
  - The range check uses N=1.
  - The RD_BURST/WR_BURST beat counter is not built.
  - `busy` is asserted only during WAIT.

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles → `data_out`=0, `busy`=0, `err`=0.
- **Single write/read:** write 32'hCAFE_F00D to `MEM_START`, then read `MEM_START` on the next edge (N=1, W=0) → `data_out`=32'hCAFE_F00D one cycle after the read edge; `busy` never 1.
- **4-beat burst:** write 1, 2, 3, 4 at `MEM_START`+0x10 with `access_size`=01 → `busy`=1,1,1,0. Then a 4-beat read → `data_out`=1, 2, 3, 4 on consecutive cycles, `busy`=1,1,1,0, and a following request is accepted with no gap.
- **Rejections:**
  - Read at `MEM_START`+2 → `err` pulses for 1 cycle, `busy`=0, `data_out` unchanged.
  - 16-beat read at `MEM_START`+4·(`DEPTH_WORDS`−8) → `err`=1, no data beats.
- **Reset mid-burst:** assert reset during the 3rd beat of a 16-beat read of a region pre-written with values 0x100 to 0x10F → next cycle `busy`=0 and `data_out`=0. A subsequent single read of word 5 returns 0x105.
- **Wait states and `BURST_EN`:**
  - `WAIT_STATES`=2, single read → `busy`=1 for 2 cycles, data valid after T2.
  - Build without `BURST_EN`, read with `access_size`=11 → exactly 1 beat returned.
